// File: rtl/test_sequencer.sv
// Test sequencer for the single-cycle CPU: preloads data memory, releases the CPU,
// waits for Done under a timeout, then checks result words and reports pass/fail.
module test_sequencer #(
    parameter int DW       = 8,
    parameter int AW       = 8,
    parameter int NPRE     = 4,
    parameter int NCHK     = 4,
    parameter int TIMEOUT  = 1024,
    parameter int RST_HOLD = 2,
    localparam int MAXN    = (NPRE > NCHK) ? NPRE : NCHK,
    localparam int IW      = (MAXN > 1) ? $clog2(MAXN) : 1,
    localparam int EW      = $clog2(NCHK + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Cfg_we,
    input  logic          Cfg_sel,
    input  logic [IW-1:0] Cfg_idx,
    input  logic          Cfg_valid,
    input  logic [AW-1:0] Cfg_addr,
    input  logic [DW-1:0] Cfg_data,
    input  logic          Start,
    input  logic          Dut_done,
    output logic          Dut_reset,
    output logic          Mem_own,
    output logic          Mem_we,
    output logic [AW-1:0] Mem_addr,
    output logic [DW-1:0] Mem_wdata,
    input  logic [DW-1:0] Mem_rdata,
    output logic          Busy,
    output logic          Pass,
    output logic          Fail,
    output logic          Timed_out,
    output logic [EW-1:0] Err_count,
    output logic [AW-1:0] Fail_addr,
    output logic [DW-1:0] Fail_data,
    output logic [15:0]   Run_cycles
);
    localparam int TD = 1 << IW;
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam int CW = (IW > HW) ? IW : ((HW > 0) ? HW : 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(NPRE - 1);
    localparam logic [CW-1:0] CHK_LAST  = CW'(NCHK - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'((RST_HOLD > 1) ? RST_HOLD - 1 : 0);
    localparam logic [IW:0]   NPRE_W    = (IW + 1)'(NPRE);
    localparam logic [IW:0]   NCHK_W    = (IW + 1)'(NCHK);

    typedef enum logic [2:0] {S_IDLE, S_PRELOAD, S_RELEASE, S_RUN, S_CHECK, S_DONE} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   run_q, run_d;
    logic [EW-1:0] err_q, err_d;
    logic [AW-1:0] faddr_q, faddr_d;
    logic [DW-1:0] fdata_q, fdata_d;
    logic          to_q, to_d, pass_q, pass_d, fail_q, fail_d, busy_q, busy_d;

    logic [TD-1:0] pre_vld_q, chk_vld_q;
    logic [AW-1:0] pre_addr_q [TD];
    logic [DW-1:0] pre_data_q [TD];
    logic [AW-1:0] chk_addr_q [TD];
    logic [DW-1:0] chk_data_q [TD];

    logic [IW-1:0] idx;
    logic          pre_wr, chk_wr, mismatch, run_tmo;

    assign idx      = cnt_q[IW-1:0];
    assign pre_wr   = (state_q == S_IDLE) && Cfg_we && !Cfg_sel && ({1'b0, Cfg_idx} < NPRE_W);
    assign chk_wr   = (state_q == S_IDLE) && Cfg_we &&  Cfg_sel && ({1'b0, Cfg_idx} < NCHK_W);
    assign mismatch = chk_vld_q[idx] && (Mem_rdata != chk_data_q[idx]);
    assign run_tmo  = (32'(run_q) + 32'd1) >= 32'(TIMEOUT);

    // Valid bits are control state and are wiped by reset; entry payloads are not.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pre_vld_q <= '0;
            chk_vld_q <= '0;
        end else begin
            if (pre_wr) pre_vld_q[Cfg_idx] <= Cfg_valid;
            if (chk_wr) chk_vld_q[Cfg_idx] <= Cfg_valid;
        end
    end

    always_ff @(posedge Clk) begin
        if (pre_wr) begin
            pre_addr_q[Cfg_idx] <= Cfg_addr;
            pre_data_q[Cfg_idx] <= Cfg_data;
        end
        if (chk_wr) begin
            chk_addr_q[Cfg_idx] <= Cfg_addr;
            chk_data_q[Cfg_idx] <= Cfg_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        err_d   = err_q;
        faddr_d = faddr_q;
        fdata_d = fdata_q;
        to_d    = to_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d = S_PRELOAD;
                    cnt_d   = '0;
                    run_d   = '0;
                    err_d   = '0;
                    to_d    = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            S_PRELOAD: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == PRE_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end
            end
            S_RELEASE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                // Done takes priority over a timeout landing on the same cycle.
                run_d = sat_inc(run_q);
                if (Dut_done) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                end else if (run_tmo) begin
                    state_d = S_DONE;
                    to_d    = 1'b1;
                    fail_d  = 1'b1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + EW'(1);
                    if (err_q == '0) begin
                        faddr_d = chk_addr_q[idx];
                        fdata_d = Mem_rdata;
                    end
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CHK_LAST) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                    fail_d  = (err_d != '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_PRELOAD) || (state_d == S_RELEASE) ||
                 (state_d == S_RUN) || (state_d == S_CHECK);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            run_q   <= '0;
            err_q   <= '0;
            faddr_q <= '0;
            fdata_q <= '0;
            to_q    <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            err_q   <= err_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
            to_q    <= to_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            busy_q  <= busy_d;
        end
    end

    // Memory port and CPU reset are decoded straight from the current state.
    always_comb begin
        Dut_reset = 1'b1;
        Mem_own   = 1'b0;
        Mem_we    = 1'b0;
        Mem_addr  = '0;
        Mem_wdata = '0;
        case (state_q)
            S_PRELOAD: begin
                Mem_own   = 1'b1;
                Mem_we    = pre_vld_q[idx];
                Mem_addr  = pre_addr_q[idx];
                Mem_wdata = pre_data_q[idx];
            end
            S_RUN: Dut_reset = 1'b0;
            S_CHECK: begin
                Mem_own  = 1'b1;
                Mem_addr = chk_addr_q[idx];
            end
            default: ;
        endcase
    end

    assign Busy       = busy_q;
    assign Pass       = pass_q;
    assign Fail       = fail_q;
    assign Timed_out  = to_q;
    assign Err_count  = err_q;
    assign Fail_addr  = faddr_q;
    assign Fail_data  = fdata_q;
    assign Run_cycles = run_q;
endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: a toy CPU + memory around the sequencer, directed
// vectors, corner sequences and randomized tables against a run-level model.
module tb_test_sequencer;
    localparam int NPRE = 4;
    localparam int NCHK = 3;
    localparam int TMO  = 64;
    localparam int HOLD = 2;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Cfg_we = 1'b0, Cfg_sel = 1'b0, Cfg_valid = 1'b0, Start = 1'b0;
    logic [1:0] Cfg_idx = '0;
    logic [7:0] Cfg_addr = '0, Cfg_data = '0;
    logic       Dut_done, Dut_reset, Mem_own, Mem_we, Busy, Pass, Fail, Timed_out;
    logic [7:0] Mem_addr, Mem_wdata, Mem_rdata, Fail_addr, Fail_data;
    logic [1:0] Err_count;
    logic [15:0] Run_cycles;

    test_sequencer #(.DW(8), .AW(8), .NPRE(NPRE), .NCHK(NCHK), .TIMEOUT(TMO), .RST_HOLD(HOLD)) dut (
        .Clk(Clk), .Reset(Reset), .Cfg_we(Cfg_we), .Cfg_sel(Cfg_sel), .Cfg_idx(Cfg_idx),
        .Cfg_valid(Cfg_valid), .Cfg_addr(Cfg_addr), .Cfg_data(Cfg_data), .Start(Start),
        .Dut_done(Dut_done), .Dut_reset(Dut_reset), .Mem_own(Mem_own), .Mem_we(Mem_we),
        .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata), .Mem_rdata(Mem_rdata), .Busy(Busy),
        .Pass(Pass), .Fail(Fail), .Timed_out(Timed_out), .Err_count(Err_count),
        .Fail_addr(Fail_addr), .Fail_data(Fail_data), .Run_cycles(Run_cycles));

    always #5 Clk = ~Clk;

    // Toy CPU: in its first unreset cycle does mem[1] = mem[0] + mem[1]; raises Done
    // in its cpu_len-th unreset cycle when cpu_halt is set.
    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    logic [7:0] mem [256] = '{default: 8'h00};
    wr_t  wr_log[$];
    int   cpu_cnt = 0;
    int   cpu_len = 5;
    bit   cpu_halt = 1'b1;

    assign Mem_rdata = mem[Mem_addr];
    assign Dut_done  = cpu_halt && !Dut_reset && (cpu_cnt == cpu_len - 1);

    always @(posedge Clk) begin
        if (Mem_own && Mem_we) begin
            mem[Mem_addr] <= Mem_wdata;
            wr_log.push_back(wr_t'{a: Mem_addr, d: Mem_wdata});
        end else if (!Dut_reset && cpu_cnt == 0) begin
            mem[1] <= mem[0] + mem[1];
        end
        cpu_cnt <= Dut_reset ? 0 : cpu_cnt + 1;
    end

    // Phase monitor: classifies each cycle of a run from the observable outputs.
    int own_pre = 0, own_chk = 0, rel_n = 0, run_n = 0;
    bit ran = 1'b0;
    always @(negedge Clk) begin
        if (Busy && Mem_own && !ran) own_pre <= own_pre + 1;
        if (Mem_own && ran) own_chk <= own_chk + 1;
        if (Busy && !Mem_own && Dut_reset && !ran) rel_n <= rel_n + 1;
        if (Busy && !Dut_reset) run_n <= run_n + 1;
        ran <= Busy && (ran || !Dut_reset);
    end

    int n_chk = 0, n_fail = 0;

    // Reference model of the tables and of one whole run.
    bit         m_pv [NPRE];
    logic [7:0] m_pa [NPRE], m_pd [NPRE];
    bit         m_cv [NCHK];
    logic [7:0] m_ca [NCHK], m_cd [NCHK];
    logic [7:0] mref [256];
    wr_t        e_log[$];
    bit         e_pass, e_to;
    int         e_err, e_run;
    logic [7:0] e_fa, e_fd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NPRE; i++) m_pv[i] = 1'b0;
        for (int i = 0; i < NCHK; i++) m_cv[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk); Reset = 1'b0;
        @(negedge Clk); Reset = 1'b1;
        clear_model();
    endtask

    task automatic cfg(input bit sel, input int idx, input bit v, input logic [7:0] a, input logic [7:0] d);
        @(negedge Clk);
        Cfg_we = 1'b1; Cfg_sel = sel; Cfg_idx = 2'(idx); Cfg_valid = v; Cfg_addr = a; Cfg_data = d;
        @(negedge Clk);
        Cfg_we = 1'b0;
        if (!sel && idx < NPRE) begin m_pv[idx] = v; m_pa[idx] = a; m_pd[idx] = d; end
        if (sel && idx < NCHK) begin m_cv[idx] = v; m_ca[idx] = a; m_cd[idx] = d; end
    endtask

    task automatic predict();
        for (int i = 0; i < 256; i++) mref[i] = mem[i];
        e_log.delete();
        for (int i = 0; i < NPRE; i++)
            if (m_pv[i]) begin mref[m_pa[i]] = m_pd[i]; e_log.push_back(wr_t'{a: m_pa[i], d: m_pd[i]}); end
        mref[1] = mref[0] + mref[1];
        e_to  = !(cpu_halt && cpu_len <= TMO);
        e_run = e_to ? TMO : cpu_len;
        e_err = 0; e_fa = 0; e_fd = 0;
        if (!e_to)
            for (int i = 0; i < NCHK; i++)
                if (m_cv[i] && mref[m_ca[i]] != m_cd[i]) begin
                    if (e_err == 0) begin e_fa = m_ca[i]; e_fd = mref[m_ca[i]]; end
                    e_err++;
                end
        e_pass = !e_to && e_err == 0;
    endtask

    task automatic pulse_start();
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!Busy) begin ok = 1'b1; break; end
            @(negedge Clk);
        end
        check({tag, "_finish"}, 32'(ok), 1);
        #1;
    endtask

    task automatic run_cmp(input string tag);
        int b_pre, b_chk, b_rel, b_run, b_wr;
        predict();
        b_pre = own_pre; b_chk = own_chk; b_rel = rel_n; b_run = run_n; b_wr = wr_log.size();
        pulse_start();
        wait_idle(tag);
        check({tag, "_pass"}, 32'(Pass), 32'(e_pass));
        check({tag, "_fail"}, 32'(Fail), 32'(!e_pass));
        check({tag, "_tmo"}, 32'(Timed_out), 32'(e_to));
        check({tag, "_err"}, 32'(Err_count), 32'(e_err));
        check({tag, "_runcyc"}, 32'(Run_cycles), 32'(e_run));
        if (e_err > 0) begin
            check({tag, "_faddr"}, 32'(Fail_addr), 32'(e_fa));
            check({tag, "_fdata"}, 32'(Fail_data), 32'(e_fd));
        end
        check({tag, "_prelen"}, 32'(own_pre - b_pre), NPRE);
        check({tag, "_rellen"}, 32'(rel_n - b_rel), HOLD);
        check({tag, "_runlen"}, 32'(run_n - b_run), 32'(e_run));
        check({tag, "_chklen"}, 32'(own_chk - b_chk), e_to ? 0 : NCHK);
        check({tag, "_nwr"}, 32'(wr_log.size() - b_wr), 32'(e_log.size()));
        for (int i = 0; i < e_log.size() && b_wr + i < wr_log.size(); i++) begin
            check({tag, "_wraddr"}, 32'(wr_log[b_wr + i].a), 32'(e_log[i].a));
            check({tag, "_wrdata"}, 32'(wr_log[b_wr + i].d), 32'(e_log[i].d));
        end
    endtask

    typedef struct {
        int         len;
        bit         halt;
        logic [7:0] chk;
        bit         x_pass;
        int         x_err;
        int         x_run;
        bit         x_to;
        logic [7:0] x_fd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{len: 5,  halt: 1, chk: 8'd7, x_pass: 1, x_err: 0, x_run: 5,  x_to: 0, x_fd: 8'd0};
        vecs[1] = '{len: 5,  halt: 1, chk: 8'd8, x_pass: 0, x_err: 1, x_run: 5,  x_to: 0, x_fd: 8'd7};
        vecs[2] = '{len: 1,  halt: 1, chk: 8'd7, x_pass: 1, x_err: 0, x_run: 1,  x_to: 0, x_fd: 8'd0};
        vecs[3] = '{len: 5,  halt: 0, chk: 8'd7, x_pass: 0, x_err: 0, x_run: 64, x_to: 1, x_fd: 8'd0};
        vecs[4] = '{len: 64, halt: 1, chk: 8'd7, x_pass: 1, x_err: 0, x_run: 64, x_to: 0, x_fd: 8'd0};
        vecs[5] = '{len: 65, halt: 1, chk: 8'd7, x_pass: 0, x_err: 0, x_run: 64, x_to: 1, x_fd: 8'd0};

        repeat (3) @(negedge Clk);
        check("rst_dutreset", 32'(Dut_reset), 1);
        check("rst_busy", 32'(Busy), 0);
        check("rst_pass", 32'(Pass), 0);
        check("rst_fail", 32'(Fail), 0);
        check("rst_tmo", 32'(Timed_out), 0);
        check("rst_err", 32'(Err_count), 0);
        check("rst_runcyc", 32'(Run_cycles), 0);
        check("rst_memown", 32'(Mem_own), 0);
        Reset = 1'b1;
        clear_model();

        // Add program vectors: mem[1]=3, mem[0]=4, CPU leaves 7 in mem[1].
        for (int v = 0; v < 6; v++) begin
            do_reset();
            cfg(0, 0, 1, 8'd1, 8'd3);
            cfg(0, 1, 1, 8'd0, 8'd4);
            cfg(1, 0, 1, 8'd1, vecs[v].chk);
            cpu_len = vecs[v].len; cpu_halt = vecs[v].halt;
            run_cmp($sformatf("vec%0d", v));
            check($sformatf("vec%0d_tpass", v), 32'(Pass), 32'(vecs[v].x_pass));
            check($sformatf("vec%0d_terr", v), 32'(Err_count), 32'(vecs[v].x_err));
            check($sformatf("vec%0d_trun", v), 32'(Run_cycles), 32'(vecs[v].x_run));
            check($sformatf("vec%0d_ttmo", v), 32'(Timed_out), 32'(vecs[v].x_to));
            if (vecs[v].x_err > 0) begin
                check($sformatf("vec%0d_tfaddr", v), 32'(Fail_addr), 1);
                check($sformatf("vec%0d_tfdata", v), 32'(Fail_data), 32'(vecs[v].x_fd));
            end
        end

        // Only preload entry 2 valid; check-table index 3 lies beyond NCHK and is dropped.
        do_reset();
        cfg(0, 2, 1, 8'd5, 8'd9);
        cfg(1, 3, 1, 8'd5, 8'd77);
        cpu_len = 3; cpu_halt = 1'b1;
        run_cmp("pre_only");
        check("pre_only_one_we", 32'(e_log.size()), 1);

        // Reset mid-RUN after 10 cycles, then a run with empty tables.
        begin
            int b_run;
            bit ok = 1'b0;
            do_reset();
            cfg(0, 0, 1, 8'd1, 8'd3);
            cfg(1, 0, 1, 8'd1, 8'd99);
            cpu_len = 40; cpu_halt = 1'b1;
            b_run = run_n;
            pulse_start();
            for (int i = 0; i < 200; i++) begin
                if (run_n - b_run >= 10) begin ok = 1'b1; break; end
                @(negedge Clk);
            end
            check("abort_reach_run", 32'(ok), 1);
            Reset = 1'b0;
            #1;
            check("abort_dutreset", 32'(Dut_reset), 1);
            check("abort_busy", 32'(Busy), 0);
            check("abort_runcyc", 32'(Run_cycles), 0);
            check("abort_memown", 32'(Mem_own), 0);
            @(negedge Clk); Reset = 1'b1;
            clear_model();
            cpu_len = 5;
            run_cmp("after_abort");
        end

        // Cfg_we during RUN and Start during CHECK must both be ignored.
        begin
            int b_chk, b_run;
            bit ok1 = 1'b0, ok2 = 1'b0;
            do_reset();
            cfg(0, 0, 1, 8'd1, 8'd3);
            cfg(0, 1, 1, 8'd0, 8'd4);
            cfg(1, 0, 1, 8'd1, 8'd7);
            cpu_len = 20; cpu_halt = 1'b1;
            b_chk = own_chk; b_run = run_n;
            pulse_start();
            for (int i = 0; i < 100; i++) begin
                if (Busy && !Dut_reset) begin ok1 = 1'b1; break; end
                @(negedge Clk);
            end
            check("ign_reach_run", 32'(ok1), 1);
            Cfg_we = 1'b1; Cfg_sel = 1'b1; Cfg_idx = 2'd0; Cfg_valid = 1'b1; Cfg_addr = 8'd1; Cfg_data = 8'd8;
            @(negedge Clk); Cfg_we = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (Mem_own && ran) begin ok2 = 1'b1; break; end
                @(negedge Clk);
            end
            check("ign_reach_check", 32'(ok2), 1);
            Start = 1'b1;
            @(negedge Clk); Start = 1'b0;
            wait_idle("ign");
            check("ign_pass", 32'(Pass), 1);
            check("ign_err", 32'(Err_count), 0);
            check("ign_runcyc", 32'(Run_cycles), 20);
            check("ign_runlen", 32'(run_n - b_run), 20);
            check("ign_chklen", 32'(own_chk - b_chk), NCHK);
            run_cmp("ign_rerun");
        end

        // Randomized tables and CPU behaviour against the run model.
        for (int it = 0; it < 30; it++) begin
            int nw;
            do_reset();
            nw = $urandom_range(3, 9);
            for (int k = 0; k < nw; k++)
                cfg(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0),
                    8'($urandom_range(0, 7)), 8'($urandom));
            cpu_len  = $urandom_range(1, 70);
            cpu_halt = ($urandom_range(0, 5) != 0);
            predict();
            for (int i = 0; i < NCHK; i++)
                if (m_cv[i] && $urandom_range(0, 1) == 1)
                    cfg(1, i, 1, m_ca[i], mref[m_ca[i]]);
            run_cmp($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
- Hardware test controller for the single-cycle CPU (Top).
- Owns the CPU's reset and the data-memory port. It preloads operand words, releases the CPU, waits for Done with a timeout, then reads back expected locations and reports pass/fail.
- Generalised in data/address width, preload depth, check depth and timeout, so directed programs are verified without per-test hand-written benches.

Parameters:
- DW, 8, data-memory word width.
- AW, 8, data-memory address width.
- NPRE, 4, preload table entries.
- NCHK, 4, check table entries.
- TIMEOUT, 1024, maximum run cycles before abort.
- RST_HOLD, 2, cycles the DUT reset stays high after preload.

Ports:
- Clk  in  1  clock.
- Reset  in  1  asynchronous active-low reset.
- Cfg_we  in  1  table write strobe; honoured only in IDLE.
- Cfg_sel  in  1  0 = preload table, 1 = check table.
- Cfg_idx  in  $clog2(max(NPRE,NCHK))  entry index.
- Cfg_valid  in  1  entry valid bit written with the entry.
- Cfg_addr  in  AW  entry memory address.
- Cfg_data  in  DW  preload value or expected value.
- Start  in  1  single-cycle pulse; begins a run from IDLE or DONE.
- Dut_done  in  1  CPU Done flag.
- Dut_reset  out  1  active-high reset to CPU.
- Mem_own  out  1  1 = sequencer drives the data-memory port.
- Mem_we  out  1  memory write enable.
- Mem_addr  out  AW  memory address.
- Mem_wdata  out  DW  memory write data.
- Mem_rdata  in  DW  memory read data, combinational (same-cycle) read.
- Busy  out  1  high in PRELOAD, RELEASE, RUN and CHECK.
- Pass  out  1  run finished, no mismatch, no timeout.
- Fail  out  1  run finished with a mismatch or a timeout.
- Timed_out  out  1  RUN aborted by timeout.
- Err_count  out  $clog2(NCHK+1)  number of mismatching checks.
- Fail_addr  out  AW  address of first mismatch.
- Fail_data  out  DW  data read at first mismatch.
- Run_cycles  out  16  cycles spent in RUN; saturates at 16'hFFFF.

Behaviour:
- Reset asserted (Reset = 0), from any state including mid-run:
  - state goes to IDLE;
  - table valid bits cleared;
  - Dut_reset = 1; Mem_own, Mem_we, Busy, Pass, Fail and Timed_out = 0;
  - counters, Err_count, Fail_addr, Fail_data and Run_cycles = 0.
- IDLE:
  - Dut_reset = 1.
  - Cfg_we writes {valid, addr, data} into the selected table at Cfg_idx.
  - An index at or beyond the table depth is ignored.
  - Start goes to PRELOAD next cycle and clears Pass, Fail, Timed_out, Err_count and Run_cycles.
- PRELOAD:
  - Scans entries 0..NPRE-1 at one entry per cycle. Mem_own = 1; Mem_we = valid bit of the entry.
  - Invalid entries still take one cycle with Mem_we = 0.
  - After the last entry, goes to RELEASE. Total PRELOAD latency is exactly NPRE cycles.
- RELEASE:
  - Dut_reset stays 1 and Mem_own = 0 for RST_HOLD cycles, then goes to RUN.
- RUN:
  - Dut_reset = 0. Run_cycles increments every cycle.
  - Dut_done sampled high goes to CHECK. The cycle that samples Done is counted.
  - If Run_cycles reaches TIMEOUT with Done low: Timed_out = 1, go to DONE and skip CHECK.
  - If Done and the timeout happen on the same cycle, Done wins.
- CHECK:
  - Dut_reset = 1, which freezes the CPU. Mem_own = 1, Mem_we = 0.
  - Scans entries 0..NCHK-1, one per cycle. For a valid entry, compares Mem_rdata with the expected value in the same cycle.
  - On a mismatch, Err_count increments. The first mismatch captures Fail_addr and Fail_data.
  - After the last entry, goes to DONE.
- DONE:
  - Dut_reset = 1, Mem_own = 0, Busy = 0.
  - Pass = (Err_count == 0) and !Timed_out; Fail = !Pass. Both are held until the next Start or reset.
- Start while Busy is ignored. Cfg_we outside IDLE is ignored.
- Dut_done is ignored outside RUN.
- All outputs are registered except Mem_* and Dut_reset, which are decoded from the current state.

Test Plan:
- Add program; preload mem[1]=3, mem[0]=4; check mem[1]=7; CPU writes 7 → Pass=1, Err_count=0, Run_cycles equals the program's cycle count.
- Same program with check expecting mem[1]=8 → Fail=1, Err_count=1, Fail_addr=1, Fail_data=7.
- Program with no halt, TIMEOUT=64 → Timed_out=1, Fail=1, Run_cycles=64, no CHECK cycles (Mem_own stays 0 after RUN).
- Preload table with only entry 2 valid (addr 5, data 9) → exactly one Mem_we pulse, at addr 5; PRELOAD lasts NPRE cycles.
- Reset pulled low during RUN after 10 cycles → IDLE next edge, Dut_reset=1, Busy=0, valid bits cleared; Start then runs no preload or check writes and Pass=1 on Done.
- Start pulsed during CHECK and Cfg_we during RUN → both ignored; tables and results unchanged.
